// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-ported register file.
package regfile_pkg;
   localparam int unsigned FILE_SIZE_DEF = 32;
   localparam int unsigned REG_SIZE_DEF  = 32;
   localparam int unsigned AW_DEF        = $clog2(FILE_SIZE_DEF);
   localparam int unsigned REG_ZERO      = 0;
endpackage

// File: rtl/regfile_wr_sel.sv
// Priority select over write ports for one address: the highest-indexed matching port wins.
module regfile_wr_sel
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_WRITE = 2,
   parameter int unsigned AW        = AW_DEF,
   parameter int unsigned REG_SIZE  = REG_SIZE_DEF
) (
   input  logic [AW-1:0]                 i_addr,
   input  logic [NUM_WRITE-1:0]          i_wr_en,
   input  logic [NUM_WRITE*AW-1:0]       i_wr_addr,
   input  logic [NUM_WRITE*REG_SIZE-1:0] i_wr_data,
   output logic                          o_hit,
   output logic [REG_SIZE-1:0]           o_data
);

   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      // Ascending scan so later (higher) ports override earlier matches.
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == i_addr)) begin
            o_hit  = 1'b1;
            o_data = i_wr_data[k*REG_SIZE +: REG_SIZE];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned FILE_SIZE = FILE_SIZE_DEF,
   parameter int unsigned REG_SIZE  = REG_SIZE_DEF,
   parameter int unsigned NUM_READ  = 4,
   parameter int unsigned NUM_WRITE = 2,
   parameter int unsigned NUM_ISSUE = 2,
   localparam int unsigned AW       = $clog2(FILE_SIZE)
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NUM_READ*AW-1:0]        i_rd_addr,
   output logic [NUM_READ*REG_SIZE-1:0]  o_rd_data,
   output logic [NUM_READ-1:0]           o_rd_busy,
   input  logic [NUM_WRITE-1:0]          i_wr_en,
   input  logic [NUM_WRITE*AW-1:0]       i_wr_addr,
   input  logic [NUM_WRITE*REG_SIZE-1:0] i_wr_data,
   input  logic [NUM_ISSUE-1:0]          i_iss_en,
   input  logic [NUM_ISSUE*AW-1:0]       i_iss_addr,
   input  logic                          i_flush,
   output logic [FILE_SIZE-1:0]          o_busy_vec
);

   logic [REG_SIZE-1:0]  w_regs    [FILE_SIZE];
   logic [REG_SIZE-1:0]  w_wr_data [FILE_SIZE];
   logic [FILE_SIZE-1:0] w_wr_hit;
   logic [FILE_SIZE-1:0] r_busy;
   logic [FILE_SIZE-1:0] w_busy_d;

   assign w_regs[REG_ZERO]    = '0;
   assign w_wr_data[REG_ZERO] = '0;
   assign w_wr_hit[REG_ZERO]  = 1'b0;

   for (genvar r = 1; r < FILE_SIZE; r++) begin : g_reg
      localparam logic [AW-1:0] ADDR = AW'(r);
      logic [REG_SIZE-1:0] r_reg;

      regfile_wr_sel #(
         .NUM_WRITE (NUM_WRITE),
         .AW        (AW),
         .REG_SIZE  (REG_SIZE)
      ) u_wr_sel (
         .i_addr    (ADDR),
         .i_wr_en   (i_wr_en),
         .i_wr_addr (i_wr_addr),
         .i_wr_data (i_wr_data),
         .o_hit     (w_wr_hit[r]),
         .o_data    (w_wr_data[r])
      );

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_reg <= '0;
         end else if (w_wr_hit[r]) begin
            r_reg <= w_wr_data[r];
         end
      end

      assign w_regs[r] = r_reg;
   end

   // Priority: flush over issue-set over writeback-clear.
   always_comb begin
      w_busy_d = r_busy;
      for (int r = 0; r < FILE_SIZE; r++) begin
         if (w_wr_hit[r]) w_busy_d[r] = 1'b0;
      end
      for (int j = 0; j < NUM_ISSUE; j++) begin
         if (i_iss_en[j]) w_busy_d[i_iss_addr[j*AW +: AW]] = 1'b1;
      end
      w_busy_d[REG_ZERO] = 1'b0;
      if (i_flush) w_busy_d = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_d;
      end
   end

   assign o_busy_vec = r_busy;

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [AW-1:0]       w_addr;
      logic [REG_SIZE-1:0] w_data;
      logic                w_busy;

      assign w_addr = i_rd_addr[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
      logic                w_byp_hit;
      logic [REG_SIZE-1:0] w_byp_data;
      logic                w_iss_hit;

      regfile_wr_sel #(
         .NUM_WRITE (NUM_WRITE),
         .AW        (AW),
         .REG_SIZE  (REG_SIZE)
      ) u_byp_sel (
         .i_addr    (w_addr),
         .i_wr_en   (i_wr_en),
         .i_wr_addr (i_wr_addr),
         .i_wr_data (i_wr_data),
         .o_hit     (w_byp_hit),
         .o_data    (w_byp_data)
      );

      always_comb begin
         w_iss_hit = 1'b0;
         for (int j = 0; j < NUM_ISSUE; j++) begin
            if (i_iss_en[j] && (i_iss_addr[j*AW +: AW] == w_addr)) w_iss_hit = 1'b1;
         end
      end

      always_comb begin
         w_data = w_regs[w_addr];
         w_busy = r_busy[w_addr];
         if (w_byp_hit && (w_addr != AW'(REG_ZERO))) begin
            w_data = w_byp_data;
            w_busy = w_iss_hit;
         end
      end
`else
      assign w_data = w_regs[w_addr];
      assign w_busy = r_busy[w_addr];
`endif

      assign o_rd_data[i*REG_SIZE +: REG_SIZE] = w_data;
      assign o_rd_busy[i]                      = w_busy;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Multi-ported, parametrised integer register file for the superscalar core, generalising the dual-issue file to NUM_READ read ports and NUM_WRITE write ports. It adds a per-register busy scoreboard: issue ports mark destinations pending, writeback ports clear them, and flush clears them all. It sits between decode/issue (reads, busy checks, destination marking) and writeback (data writes).

Parameters:
FILE_SIZE, 32, number of architectural registers (power of two, >=2)
REG_SIZE, 32, data width in bits
NUM_READ, 4, number of read ports
NUM_WRITE, 2, number of write/writeback ports
NUM_ISSUE, 2, number of destination-marking issue ports

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NUM_READ*AW  read addresses, port i at [i*AW +: AW], AW=$clog2(FILE_SIZE)
rd_data  out  NUM_READ*REG_SIZE  read data per port
rd_busy  out  NUM_READ  scoreboard busy bit of each read address
wr_en  in  NUM_WRITE  write enable per port
wr_addr  in  NUM_WRITE*AW  write addresses
wr_data  in  NUM_WRITE*REG_SIZE  write data
iss_en  in  NUM_ISSUE  mark destination pending
iss_addr  in  NUM_ISSUE*AW  destination address per issue port
flush  in  1  synchronous clear of every busy bit
busy_vec  out  FILE_SIZE  full scoreboard, bit r = register r pending

Behaviour:
- Clock clk, single domain. reset is asynchronous and active-low: on assertion all registers = 0, all busy bits = 0, immediately. So rd_data = 0, rd_busy = 0, busy_vec = 0 while in reset.
- Register 0: reads return 0 and busy 0. Writes and issue marks to address 0 are ignored.
- Reads are combinational from array state, with zero added latency.
- Writes commit on the rising edge. When several enabled write ports target the same address, the highest-indexed port wins (port NUM_WRITE-1 has top priority). Writes to distinct addresses all commit.
- Scoreboard per register r != 0, next-state priority, highest first:
  1. flush = 1 -> 0 for every r, including r targeted by iss_en that cycle.
  2. Any iss_en[j] with iss_addr[j] = r -> 1. Set beats a same-cycle clear, because the new producer supersedes the old one.
  3. Any wr_en[k] with wr_addr[k] = r -> 0.
  4. Otherwise hold.
- Data writes are independent of flush: a write in a flush cycle still updates the array.
- Duplicate iss_addr across issue ports is legal and sets the bit once.
- Writing a non-busy register is legal: data updates and busy stays 0.
- Reset asserted mid-cycle overrides any pending write, issue or flush. The first edge after release behaves normally.
- Out-of-range addresses cannot occur because FILE_SIZE is a power of two.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: each read port forwards same-cycle write data. If any wr_en[k] has wr_addr[k] = rd_addr[i] != 0, then rd_data[i] takes the highest-priority matching wr_data and rd_busy[i] = 0, unless an iss_en in the same cycle targets that address, in which case busy reads 1. This is a combinational path from wr_* to rd_*.
- Not defined: reads show array state only. A written value becomes visible the cycle after the write edge, and rd_busy reflects the registered scoreboard.

Decomposition:
- Package regfile_pkg holds defaults FILE_SIZE/REG_SIZE, the derived AW, and the REG_ZERO address constant.
- Sub-module regfile_wr_sel: per-register priority encoder over write ports, producing a one-hot-resolved write enable and selected data. The same module is reused for the bypass mux under REGFILE_BYPASS_EN.
- The scoreboard stays inline.

Test Plan:
- Reset then release. Read all four ports at addresses 0, 1, 17, 31 -> rd_data = 0 and busy_vec = 0. Assert reset mid-stream after writing r5 = 0xDEAD -> r5 reads 0 immediately.
- wr_en = 2'b11, both to r7, data 0x1111 (port 0) and 0x2222 (port 1) -> next cycle r7 = 0x2222. Distinct addresses r3/r4 -> both updated.
- iss_en[0] on r9 -> busy_vec[9] = 1 next cycle. Later wr_en[1] on r9 with 0xABCD -> busy clears and r9 = 0xABCD.
- Same cycle: iss_en on r12 and wr_en on r12 (r12 busy) -> busy_vec[12] stays 1 and data is updated.
- Set busy on r2, r3, r4, then flush = 1 with iss_en on r5 -> busy_vec = 0 next cycle. Write to r0 of 0xFFFF plus iss_en on r0 -> r0 reads 0 and is never busy.
- With REGFILE_BYPASS_EN: wr_en on r6 = 0x5A5A while rd_addr[2] = 6 -> rd_data[2] = 0x5A5A in the same cycle. Without the macro: old value that cycle, 0x5A5A the next.
